// File: rtl/ibex_imem_arbiter_pkg.sv
// Shared definitions for the instruction-memory arbiter: capability width,
// requester IDs and the outstanding-count width.
package ibex_defines;

    localparam int unsigned CAP_SIZE              = 93;
    localparam int unsigned MAX_OUTSTANDING_LIMIT = 4;
    localparam int unsigned IMEM_CNT_W            = $clog2(MAX_OUTSTANDING_LIMIT + 1);

    typedef enum logic {
        IMEM_SRC_FETCH = 1'b0,
        IMEM_SRC_AUX   = 1'b1
    } imem_src_e;

    function automatic imem_src_e imem_src_other(input imem_src_e src);
        return (src == IMEM_SRC_FETCH) ? IMEM_SRC_AUX : IMEM_SRC_FETCH;
    endfunction

endpackage

// File: rtl/ibex_imem_arbiter_id_fifo.sv
// In-order FIFO of requester IDs for granted-but-unanswered memory requests.
// IDs are one bit wide, so the storage is a packed shift vector with the head at bit 0.
module ibex_imem_id_fifo
    import ibex_defines::*;
#(
    parameter int unsigned Depth = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  push,
    input  imem_src_e             push_id,
    input  logic                  pop,
    output logic                  full,
    output logic                  empty,
    output imem_src_e             head,
    output logic [IMEM_CNT_W-1:0] count
);

    logic [Depth-1:0]      ids_q;
    logic [Depth-1:0]      ids_shift;
    logic [Depth-1:0]      wr_mask;
    logic [Depth-1:0]      ids_d;
    logic [IMEM_CNT_W-1:0] count_q;
    logic [IMEM_CNT_W-1:0] wr_idx;
    logic                  pop_en;
    logic                  push_en;

    assign empty   = (count_q == '0);
    assign full    = (count_q == IMEM_CNT_W'(Depth));
    assign pop_en  = pop & ~empty;
    assign push_en = push & (~full | pop_en);
    assign head    = imem_src_e'(ids_q[0]);
    assign count   = count_q;

    // On a simultaneous pop the new entry lands one slot lower, after the shift.
    always_comb begin
        wr_idx    = pop_en ? (count_q - IMEM_CNT_W'(1)) : count_q;
        ids_shift = pop_en ? (ids_q >> 1) : ids_q;
        wr_mask   = push_en ? (Depth'(1) << wr_idx) : '0;
        ids_d     = (ids_shift & ~wr_mask) | (wr_mask & {Depth{push_id == IMEM_SRC_AUX}});
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ids_q   <= '0;
            count_q <= '0;
        end else begin
            ids_q <= ids_d;
            case ({push_en, pop_en})
                2'b10:   count_q <= count_q + IMEM_CNT_W'(1);
                2'b01:   count_q <= count_q - IMEM_CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/ibex_imem_arbiter.sv
// Arbitrates the fetch and auxiliary ports onto one instruction memory port.
// Define IBEX_IMEM_ARB_RR_EN for round-robin arbitration; otherwise fetch has fixed priority.
module ibex_imem_arbiter
    import ibex_defines::*;
#(
    parameter int unsigned MaxOutstanding = 2
) (
    input  logic                clk_i,
    input  logic                rst_ni,

    input  logic                f_req_i,
    input  logic [CAP_SIZE-1:0] f_cap_i,
    input  logic [31:0]         f_addr_i,
    output logic                f_gnt_o,
    output logic                f_rvalid_o,
    output logic [31:0]         f_rdata_o,

    input  logic                a_req_i,
    input  logic [CAP_SIZE-1:0] a_cap_i,
    input  logic [31:0]         a_addr_i,
    output logic                a_gnt_o,
    output logic                a_rvalid_o,
    output logic [31:0]         a_rdata_o,

    output logic                instr_req_o,
    output logic [CAP_SIZE-1:0] instr_cap_o,
    output logic [31:0]         instr_addr_o,
    input  logic                instr_gnt_i,
    input  logic                instr_rvalid_i,
    input  logic [31:0]         instr_rdata_i,

    output logic                busy_o,
    output logic                err_o
);

    logic                  lock_q;
    imem_src_e             lock_src_q;
    imem_src_e             arb_src;
    imem_src_e             sel_src;
    logic                  sel_valid;
    logic                  sel_req;
    logic                  grant;
    logic                  rsp_hit;
    logic                  err_q;
    logic                  fifo_full;
    logic                  fifo_empty;
    imem_src_e             fifo_head;
    logic [IMEM_CNT_W-1:0] fifo_count;

`ifdef IBEX_IMEM_ARB_RR_EN
    imem_src_e last_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_q <= IMEM_SRC_AUX;
        end else if (grant) begin
            last_q <= sel_src;
        end
    end

    always_comb begin
        arb_src = IMEM_SRC_AUX;
        if (f_req_i && a_req_i) begin
            arb_src = imem_src_other(last_q);
        end else if (f_req_i) begin
            arb_src = IMEM_SRC_FETCH;
        end
    end
`else
    assign arb_src = f_req_i ? IMEM_SRC_FETCH : IMEM_SRC_AUX;
`endif

    // Outputs are forced low while reset is asserted, including the purely combinational paths.
    always_comb begin
        sel_src   = lock_q ? lock_src_q : arb_src;
        sel_valid = lock_q | f_req_i | a_req_i;
        sel_req   = (sel_src == IMEM_SRC_FETCH) ? f_req_i : a_req_i;

        instr_req_o  = rst_ni & sel_req & ~fifo_full;
        instr_cap_o  = '0;
        instr_addr_o = '0;
        if (rst_ni && sel_valid) begin
            instr_cap_o  = (sel_src == IMEM_SRC_FETCH) ? f_cap_i  : a_cap_i;
            instr_addr_o = (sel_src == IMEM_SRC_FETCH) ? f_addr_i : a_addr_i;
        end

        grant   = instr_req_o & instr_gnt_i;
        f_gnt_o = grant & (sel_src == IMEM_SRC_FETCH);
        a_gnt_o = grant & (sel_src == IMEM_SRC_AUX);

        rsp_hit    = rst_ni & instr_rvalid_i & ~fifo_empty;
        f_rvalid_o = rsp_hit & (fifo_head == IMEM_SRC_FETCH);
        a_rvalid_o = rsp_hit & (fifo_head == IMEM_SRC_AUX);
        f_rdata_o  = rst_ni ? instr_rdata_i : '0;
        a_rdata_o  = rst_ni ? instr_rdata_i : '0;

        busy_o = rst_ni & ((fifo_count != '0) | f_req_i | a_req_i);
        err_o  = err_q;
    end

    // A request left waiting for its grant pins the selection for the next cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lock_q     <= 1'b0;
            lock_src_q <= IMEM_SRC_FETCH;
            err_q      <= 1'b0;
        end else begin
            lock_q     <= instr_req_o & ~instr_gnt_i;
            lock_src_q <= sel_src;
            err_q      <= instr_rvalid_i & fifo_empty;
        end
    end

    ibex_imem_id_fifo #(
        .Depth (MaxOutstanding)
    ) u_id_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push    (grant),
        .push_id (sel_src),
        .pop     (instr_rvalid_i),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .head    (fifo_head),
        .count   (fifo_count)
    );

endmodule

// File: tb/tb_ibex_imem_arbiter.sv
// Scoreboard bench for ibex_imem_arbiter: per-cycle reference model plus an rvalid monitor.
module tb_ibex_imem_arbiter;
    import ibex_defines::*;

    localparam int unsigned MAXO = 2;

    typedef struct {
        imem_src_e   src;
        logic [31:0] data;
    } rsp_t;

    logic                clk = 1'b0;
    logic                rst_n = 1'b1;
    logic                f_req = 1'b0, a_req = 1'b0;
    logic [CAP_SIZE-1:0] f_cap = '0, a_cap = '0;
    logic [31:0]         f_addr = '0, a_addr = '0;
    logic                f_gnt, a_gnt, f_rvalid, a_rvalid;
    logic [31:0]         f_rdata, a_rdata;
    logic                instr_req;
    logic [CAP_SIZE-1:0] instr_cap;
    logic [31:0]         instr_addr;
    logic                instr_gnt = 1'b0, instr_rvalid = 1'b0;
    logic [31:0]         instr_rdata = '0;
    logic                busy, err;

    int unsigned checks = 0;
    int unsigned errors = 0;

    rsp_t        mq[$];
    rsp_t        sb[$];
    logic        m_locked = 1'b0;
    imem_src_e   m_lsrc = IMEM_SRC_FETCH;
    imem_src_e   m_last = IMEM_SRC_AUX;
    logic        m_err = 1'b0;

    logic        s_req, s_fgnt, s_agnt, s_frv, s_arv, s_busy;
    logic [31:0] s_addr, s_frdata;

    always #5 clk = ~clk;

    ibex_imem_arbiter #(.MaxOutstanding(MAXO)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .f_req_i        (f_req),
        .f_cap_i        (f_cap),
        .f_addr_i       (f_addr),
        .f_gnt_o        (f_gnt),
        .f_rvalid_o     (f_rvalid),
        .f_rdata_o      (f_rdata),
        .a_req_i        (a_req),
        .a_cap_i        (a_cap),
        .a_addr_i       (a_addr),
        .a_gnt_o        (a_gnt),
        .a_rvalid_o     (a_rvalid),
        .a_rdata_o      (a_rdata),
        .instr_req_o    (instr_req),
        .instr_cap_o    (instr_cap),
        .instr_addr_o   (instr_addr),
        .instr_gnt_i    (instr_gnt),
        .instr_rvalid_i (instr_rvalid),
        .instr_rdata_i  (instr_rdata),
        .busy_o         (busy),
        .err_o          (err)
    );

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return (a == 32'h100) ? 32'hDEAD_BEEF : ((a ^ 32'h5A5A_0000) + 32'h11);
    endfunction

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One bus cycle: apply inputs at posedge+1, compare against the model at posedge+4.
    task automatic cycle(input logic fr, input logic ar, input logic [31:0] fa,
                         input logic [31:0] aa, input logic g, input logic rv);
        imem_src_e           sel;
        logic                sv, sreq, ereq, egr, efrv, earv, eerr_n;
        logic [31:0]         eaddr;
        logic [CAP_SIZE-1:0] ecap;
        f_req = fr;  a_req = ar;  f_addr = fa;  a_addr = aa;
        f_cap = CAP_SIZE'({$urandom(), $urandom(), $urandom()});
        a_cap = CAP_SIZE'({$urandom(), $urandom(), $urandom()});
        instr_gnt = g;  instr_rvalid = rv;
        instr_rdata = (rv && mq.size() != 0) ? mq[0].data : $urandom();
        #3;
        if (m_locked) begin
            sel = m_lsrc;
            sv  = 1'b1;
        end else begin
            sv  = fr | ar;
            sel = fr ? IMEM_SRC_FETCH : IMEM_SRC_AUX;
`ifdef IBEX_IMEM_ARB_RR_EN
            if (fr && ar) sel = (m_last == IMEM_SRC_FETCH) ? IMEM_SRC_AUX : IMEM_SRC_FETCH;
`endif
        end
        sreq  = (sel == IMEM_SRC_FETCH) ? fr : ar;
        ereq  = sreq && (mq.size() < MAXO);
        egr   = ereq && g;
        eaddr = !sv ? 32'h0 : ((sel == IMEM_SRC_FETCH) ? fa : aa);
        ecap  = !sv ? '0 : ((sel == IMEM_SRC_FETCH) ? f_cap : a_cap);
        efrv  = rv && mq.size() != 0 && mq[0].src == IMEM_SRC_FETCH;
        earv  = rv && mq.size() != 0 && mq[0].src == IMEM_SRC_AUX;
        chk("instr_req",  96'(instr_req),  96'(ereq));
        chk("instr_addr", 96'(instr_addr), 96'(eaddr));
        chk("instr_cap",  96'(instr_cap),  96'(ecap));
        chk("f_gnt",      96'(f_gnt),      96'(egr && sel == IMEM_SRC_FETCH));
        chk("a_gnt",      96'(a_gnt),      96'(egr && sel == IMEM_SRC_AUX));
        chk("f_rvalid",   96'(f_rvalid),   96'(efrv));
        chk("a_rvalid",   96'(a_rvalid),   96'(earv));
        chk("err",        96'(err),        96'(m_err));
        chk("busy",       96'(busy),       96'(mq.size() != 0 || fr || ar));
        s_req = instr_req;  s_addr = instr_addr;  s_fgnt = f_gnt;  s_agnt = a_gnt;
        s_frv = f_rvalid;   s_arv = a_rvalid;     s_frdata = f_rdata;  s_busy = busy;
        eerr_n = rv && mq.size() == 0;
        if (rv && mq.size() != 0) void'(mq.pop_front());
        if (egr) begin
            rsp_t r;
            r.src  = sel;
            r.data = mem_data((sel == IMEM_SRC_FETCH) ? fa : aa);
            mq.push_back(r);
            sb.push_back(r);
            m_last = sel;
        end
        m_locked = ereq && !g;
        m_lsrc   = sel;
        m_err    = eerr_n;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        f_req = 1'b1;  a_req = 1'b1;  f_addr = 32'h300;  a_addr = 32'h400;
        f_cap = '1;    a_cap = '1;    instr_gnt = 1'b1;  instr_rvalid = 1'b1;
        instr_rdata = 32'hFFFF_FFFF;
        #1;
        chk("rst_instr_req",  96'(instr_req),  96'(0));
        chk("rst_instr_addr", 96'(instr_addr), 96'(0));
        chk("rst_instr_cap",  96'(instr_cap),  96'(0));
        chk("rst_gnt",        96'({f_gnt, a_gnt}), 96'(0));
        chk("rst_rvalid",     96'({f_rvalid, a_rvalid}), 96'(0));
        chk("rst_rdata",      96'({f_rdata, a_rdata}), 96'(0));
        chk("rst_busy",       96'(busy), 96'(0));
        chk("rst_err",        96'(err),  96'(0));
        mq.delete();  sb.delete();
        m_locked = 1'b0;  m_last = IMEM_SRC_AUX;  m_err = 1'b0;
        repeat (2) @(posedge clk);
        f_req = 1'b0;  a_req = 1'b0;  instr_gnt = 1'b0;  instr_rvalid = 1'b0;
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Response monitor: every port rvalid must match the oldest expected response.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && (f_rvalid || a_rvalid)) begin
                chk("rv_onehot", 96'(f_rvalid & a_rvalid), 96'(0));
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL sb_spurious: got rvalid f=%0b a=%0b, expected none", f_rvalid, a_rvalid);
                end else begin
                    rsp_t r;
                    r = sb.pop_front();
                    chk("sb_port", 96'(f_rvalid ? IMEM_SRC_FETCH : IMEM_SRC_AUX), 96'(r.src));
                    chk("sb_data", 96'(f_rvalid ? f_rdata : a_rdata), 96'(r.data));
                end
            end
        end
    end

    initial begin
        #1;
        do_reset();

        // Stray rvalid with nothing outstanding
        cycle(0, 0, 32'h0, 32'h0, 0, 1);
        chk("t030_frv", 96'(s_frv), 96'(0));
        chk("t030_arv", 96'(s_arv), 96'(0));
        chk("t030_err_set", 96'(err), 96'(1));
        cycle(0, 0, 32'h0, 32'h0, 0, 0);
        chk("t030_err_clr", 96'(err), 96'(0));

        // Single fetch, response two cycles after grant
        cycle(1, 0, 32'h100, 32'h0, 1, 0);
        chk("t026_req",  96'(s_req),  96'(1));
        chk("t026_addr", 96'(s_addr), 96'(32'h100));
        chk("t026_fgnt", 96'(s_fgnt), 96'(1));
        cycle(0, 0, 32'h0, 32'h0, 0, 0);
        chk("t026_fgnt_low", 96'(s_fgnt), 96'(0));
        cycle(0, 0, 32'h0, 32'h0, 0, 1);
        chk("t026_frv",   96'(s_frv),    96'(1));
        chk("t026_rdata", 96'(s_frdata), 96'(32'hDEAD_BEEF));
        chk("t026_arv",   96'(s_arv),    96'(0));

        // Both ports requesting continuously
        do_reset();
        for (int i = 0; i < 8; i++) begin
            cycle(1, 1, 32'h1000 + 32'(i) * 4, 32'h2000 + 32'(i) * 4, 1, i != 0);
`ifdef IBEX_IMEM_ARB_RR_EN
            chk("t027_fgnt", 96'(s_fgnt), 96'((i % 2) == 0));
            chk("t027_agnt", 96'(s_agnt), 96'((i % 2) == 1));
`else
            chk("t027_fgnt", 96'(s_fgnt), 96'(1));
            chk("t027_agnt", 96'(s_agnt), 96'(0));
`endif
        end
        cycle(0, 0, 32'h0, 32'h0, 0, 1);

        // Aux locked while grant is withheld, fetch arrives meanwhile
        cycle(0, 1, 32'h180, 32'h200, 0, 0);
        chk("t028_addr0", 96'(s_addr), 96'(32'h200));
        chk("t028_fgnt0", 96'(s_fgnt), 96'(0));
        for (int k = 0; k < 2; k++) begin
            cycle(1, 1, 32'h180, 32'h200, 0, 0);
            chk("t028_addr", 96'(s_addr), 96'(32'h200));
            chk("t028_fgnt", 96'(s_fgnt), 96'(0));
        end
        cycle(1, 1, 32'h180, 32'h200, 1, 0);
        chk("t028_addr_g", 96'(s_addr), 96'(32'h200));
        chk("t028_agnt",   96'(s_agnt), 96'(1));
        chk("t028_fgnt_g", 96'(s_fgnt), 96'(0));
        cycle(1, 0, 32'h180, 32'h200, 1, 0);
        chk("t028_fgnt_after", 96'(s_fgnt), 96'(1));
        cycle(0, 0, 32'h0, 32'h0, 0, 1);
        chk("t028_order_a", 96'(s_arv), 96'(1));
        cycle(0, 0, 32'h0, 32'h0, 0, 1);
        chk("t028_order_f", 96'(s_frv), 96'(1));

        // Outstanding limit and simultaneous push/pop
        cycle(1, 0, 32'h300, 32'h0, 1, 0);
        cycle(0, 1, 32'h0, 32'h304, 1, 0);
        cycle(1, 0, 32'h308, 32'h0, 1, 0);
        chk("t029_req_gated", 96'(s_req),  96'(0));
        chk("t029_fgnt_gated", 96'(s_fgnt), 96'(0));
        cycle(1, 0, 32'h308, 32'h0, 1, 1);
        chk("t029_req_gated2", 96'(s_req), 96'(0));
        chk("t029_frv1", 96'(s_frv), 96'(1));
        cycle(1, 0, 32'h308, 32'h0, 1, 1);
        chk("t029_pp_fgnt", 96'(s_fgnt), 96'(1));
        chk("t029_pp_arv",  96'(s_arv),  96'(1));
        cycle(0, 1, 32'h0, 32'h30C, 1, 0);
        chk("t029_agnt", 96'(s_agnt), 96'(1));
        cycle(1, 0, 32'h310, 32'h0, 1, 0);
        chk("t029_full_again", 96'(s_req), 96'(0));
        cycle(0, 0, 32'h0, 32'h0, 0, 1);
        chk("t029_order_f", 96'(s_frv), 96'(1));
        cycle(0, 0, 32'h0, 32'h0, 0, 1);
        chk("t029_order_a", 96'(s_arv), 96'(1));

        // Reset with a fetch in flight
        cycle(1, 0, 32'h400, 32'h0, 1, 0);
        do_reset();
        cycle(0, 0, 32'h0, 32'h0, 0, 0);
        chk("t031_busy", 96'(s_busy), 96'(0));
        cycle(0, 0, 32'h0, 32'h0, 0, 1);
        chk("t031_stale_frv", 96'(s_frv), 96'(0));
        chk("t031_stale_err", 96'(err), 96'(1));
        cycle(0, 0, 32'h0, 32'h0, 0, 0);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            logic fr, ar, g, rv;
            fr = $urandom_range(0, 99) < 60;
            ar = $urandom_range(0, 99) < 50;
            g  = $urandom_range(0, 99) < 60;
            rv = (mq.size() != 0) ? ($urandom_range(0, 99) < 50) : ($urandom_range(0, 99) < 5);
            cycle(fr, ar, $urandom() & 32'hFFFF_FFFC, $urandom() & 32'hFFFF_FFFC, g, rv);
        end
        for (int d = 0; d < 8 && mq.size() != 0; d++) begin
            cycle(0, 0, 32'h0, 32'h0, 0, 1);
        end
        @(negedge clk);
        chk("sb_drained", 96'(sb.size()), 96'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
